// File: rtl/vending_machine.sv
// Coin-operated vending controller: edge-detected buttons feed a 14-bit credit
// register, a four-item purchase path, status lamps and a scanned 4-digit display.
module vending_machine #(
    parameter int PRICE0      = 300,
    parameter int PRICE1      = 500,
    parameter int PRICE2      = 700,
    parameter int PRICE3      = 1000,
    parameter int CREDIT_MAX  = 9900,
    parameter int REFRESH_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       L_button,
    input  logic       R_button,
    input  logic       C_button,
    input  logic [3:0] switch,
    output logic [7:0] DIGIT,
    output logic [6:0] SEG,
    output logic [9:0] LED
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [13:0] P0 = 14'(PRICE0);
    localparam logic [13:0] P1 = 14'(PRICE1);
    localparam logic [13:0] P2 = 14'(PRICE2);
    localparam logic [13:0] P3 = 14'(PRICE3);

    // Bit order in the button vectors: {C, R, L}
    logic [2:0]    b_q, b_prev, ev;
    logic [13:0]   credit, credit_nxt;
    logic [5:0]    led_hi, led_hi_nxt;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    scan_idx;

    logic [13:0] price;
    logic        price_ok;
    logic [13:0] coin;
    logic [14:0] coin_sum;
    logic [3:0]  bcd0, bcd1, bcd2, bcd3, cur_digit;

    assign ev = b_q & ~b_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            b_q      <= '0;
            b_prev   <= '0;
            credit   <= '0;
            led_hi   <= '0;
            scan_cnt <= '0;
            scan_idx <= '0;
        end else begin
            b_q    <= {C_button, R_button, L_button};
            b_prev <= b_q;
            credit <= credit_nxt;
            led_hi <= led_hi_nxt;
            if (scan_cnt == CW'(REFRESH_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= scan_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        price    = P0;
        price_ok = 1'b1;
        case (switch)
            4'b0001: price = P0;
            4'b0010: price = P1;
            4'b0100: price = P2;
            4'b1000: price = P3;
            default: price_ok = 1'b0;
        endcase
    end

    assign coin     = ev[1] ? 14'd500 : 14'd100;
    assign coin_sum = {1'b0, credit} + {1'b0, coin};

    // C outranks R outranks L; a lower-priority event in the same cycle is dropped.
    always_comb begin
        credit_nxt = credit;
        led_hi_nxt = led_hi;
        if (ev[2]) begin
            if (switch == 4'b0000) begin
                led_hi_nxt = {1'b0, (credit != 14'd0), 4'b0000};
                credit_nxt = '0;
            end else if (price_ok && credit >= price) begin
                credit_nxt = credit - price;
                led_hi_nxt = {2'b00, switch};
            end else begin
                led_hi_nxt = 6'b100000;
            end
        end else if (ev[1] || ev[0]) begin
            if (coin_sum <= 15'(CREDIT_MAX)) begin
                credit_nxt = coin_sum[13:0];
                led_hi_nxt = 6'b000000;
            end else begin
                led_hi_nxt = 6'b100000;
            end
        end
    end

    assign LED = {led_hi, (credit >= P3), (credit >= P2), (credit >= P1), (credit >= P0)};

    assign bcd0 = 4'(credit % 14'd10);
    assign bcd1 = 4'((credit / 14'd10) % 14'd10);
    assign bcd2 = 4'((credit / 14'd100) % 14'd10);
    assign bcd3 = 4'((credit / 14'd1000) % 14'd10);

    always_comb begin
        case (scan_idx)
            2'd0:    cur_digit = bcd0;
            2'd1:    cur_digit = bcd1;
            2'd2:    cur_digit = bcd2;
            default: cur_digit = bcd3;
        endcase
    end

    always_comb begin
        case (cur_digit)
            4'd0:    SEG = 7'b1000000;
            4'd1:    SEG = 7'b1111001;
            4'd2:    SEG = 7'b0100100;
            4'd3:    SEG = 7'b0110000;
            4'd4:    SEG = 7'b0011001;
            4'd5:    SEG = 7'b0010010;
            4'd6:    SEG = 7'b0000010;
            4'd7:    SEG = 7'b1111000;
            4'd8:    SEG = 7'b0000000;
            4'd9:    SEG = 7'b0010000;
            default: SEG = 7'b1111111;
        endcase
    end

    assign DIGIT = {4'hF, ~(4'b0001 << scan_idx)};

endmodule

// File: tb/tb_vending_machine.sv
// Bench for vending_machine: a behavioural credit/lamp model feeds an expected
// queue; lamps and the scanned display are compared after each button action.
module tb_vending_machine;

    localparam int REFRESH_DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       L_button = 1'b0;
    logic       R_button = 1'b0;
    logic       C_button = 1'b0;
    logic [3:0] switch = 4'b0000;
    logic [7:0] DIGIT;
    logic [6:0] SEG;
    logic [9:0] LED;

    vending_machine #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk(clk), .rst(rst), .L_button(L_button), .R_button(R_button),
        .C_button(C_button), .switch(switch), .DIGIT(DIGIT), .SEG(SEG), .LED(LED)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int credit_m = 0;
    logic [5:0] led_m = '0;
    logic [23:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [9:0] led_full();
        return {led_m, (credit_m >= 1000), (credit_m >= 700), (credit_m >= 500), (credit_m >= 300)};
    endfunction

    function automatic int seg_to_num(input logic [6:0] s);
        case (s)
            7'b1000000: return 0;
            7'b1111001: return 1;
            7'b0100100: return 2;
            7'b0110000: return 3;
            7'b0011001: return 4;
            7'b0010010: return 5;
            7'b0000010: return 6;
            7'b1111000: return 7;
            7'b0000000: return 8;
            7'b0010000: return 9;
            default:    return 15;
        endcase
    endfunction

    // Behavioural model of one button event (C > R > L)
    task automatic model_event(input logic l, input logic r, input logic c);
        int price;
        int coin;
        if (c) begin
            if (switch == 4'b0000) begin
                led_m = {1'b0, (credit_m != 0), 4'b0000};
                credit_m = 0;
            end else if ($countones(switch) == 1) begin
                price = switch[0] ? 300 : switch[1] ? 500 : switch[2] ? 700 : 1000;
                if (credit_m >= price) begin
                    credit_m -= price;
                    led_m = {2'b00, switch};
                end else begin
                    led_m = 6'b100000;
                end
            end else begin
                led_m = 6'b100000;
            end
        end else if (r || l) begin
            coin = r ? 500 : 100;
            if (credit_m + coin <= 9900) begin
                credit_m += coin;
                led_m = 6'b000000;
            end else begin
                led_m = 6'b100000;
            end
        end
    endtask

    // Reads the four scanned digits (ones first) and assembles the shown value
    task automatic read_display(output int value);
        logic [3:0] want;
        int d;
        int budget;
        value = 0;
        for (int k = 0; k < 4; k++) begin
            want = ~(4'b0001 << k);
            budget = 5 * REFRESH_DIV;
            while (DIGIT[3:0] !== want && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (budget == 0) begin
                check("scan_timeout", 32'd0, 32'd1);
                return;
            end
            if (k == 0) check("digit_hi", {28'd0, DIGIT[7:4]}, 32'hF);
            d = seg_to_num(SEG);
            value += d * ((k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000);
        end
    endtask

    task automatic check_out();
        logic [23:0] item;
        int shown;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        item = exp_q.pop_front();
        check("led", {22'd0, LED}, {22'd0, item[9:0]});
        read_display(shown);
        check("credit", shown, {18'd0, item[23:10]});
    endtask

    task automatic press(input logic l, input logic r, input logic c, input int hold);
        @(negedge clk);
        L_button = l;
        R_button = r;
        C_button = c;
        model_event(l, r, c);
        exp_q.push_back({14'(credit_m), led_full()});
        repeat (hold) @(negedge clk);
        L_button = 1'b0;
        R_button = 1'b0;
        C_button = 1'b0;
        @(negedge clk);
        check_out();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digit"}, {24'd0, DIGIT}, 32'hFE);
        check({tag, "_seg"}, {25'd0, SEG}, 32'h40);
        check({tag, "_led"}, {22'd0, LED}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int shown;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        read_display(shown);
        check("reset_credit", shown, 32'd0);

        // three 100 coins -> 300, item 0 lamp only
        repeat (3) press(1'b1, 1'b0, 1'b0, 1);

        // buy item 0, then attempt item 1 with no credit
        switch = 4'b0001;
        press(1'b0, 1'b0, 1'b1, 1);
        switch = 4'b0010;
        press(1'b0, 1'b0, 1'b1, 1);

        // two 500 coins then coin return; next coin clears the return lamp
        press(1'b0, 1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 1'b0, 1);
        switch = 4'b0000;
        press(1'b0, 1'b0, 1'b1, 1);
        press(1'b1, 1'b0, 1'b0, 1);

        // long hold, simultaneous coins, confirm beating a coin
        press(1'b1, 1'b0, 1'b0, 50);
        press(1'b1, 1'b1, 1'b0, 1);
        switch = 4'b0100;
        press(1'b1, 1'b0, 1'b1, 1);
        switch = 4'b0000;
        press(1'b0, 1'b0, 1'b1, 1);

        // fill to the ceiling and overflow it
        repeat (19) press(1'b0, 1'b1, 1'b0, 1);
        repeat (4) press(1'b1, 1'b0, 1'b0, 1);
        press(1'b1, 1'b0, 1'b0, 1);
        press(1'b0, 1'b1, 1'b0, 1);
        switch = 4'b0011;
        press(1'b0, 1'b0, 1'b1, 1);

        // switch noise without a confirm changes nothing
        exp_q.push_back({14'(credit_m), led_full()});
        repeat (30) begin
            @(negedge clk);
            switch = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        check_out();

        switch = 4'b0100;
        press(1'b0, 1'b0, 1'b1, 1);
        switch = 4'b1000;
        press(1'b0, 1'b0, 1'b1, 1);

        // reset mid-operation with L held through release
        @(negedge clk);
        rst = 1'b0;
        L_button = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        credit_m = 0;
        led_m = '0;
        rst = 1'b1;
        model_event(1'b1, 1'b0, 1'b0);
        exp_q.push_back({14'(credit_m), led_full()});
        repeat (6) @(negedge clk);
        L_button = 1'b0;
        @(negedge clk);
        check_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
